fifo_uart_tx: RTL

- Downstream consumer of the 8-bit byte FIFO.
- Pops one byte at a time through the FIFO read handshake and serialises it onto a UART line: 8N1, LSB first.
- Sits between the FIFO and the board TX pin.
- Pure drain: never writes the FIFO.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and frame-length helper.
// Optional macro FIFO_UART_TX_PARITY_EN adds the PARITY state (even parity bit).
package uart_pkg;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

    localparam int PARITY_BITS = 1;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    localparam int PARITY_BITS = 0;
`endif

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_len(input int clks_per_bit, input int data_w);
        return (data_w + 2 + PARITY_BITS) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and strobes on the
// terminal count; pre_tick flags the cycle before it so callers can register outputs.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick     = enable && (count == LAST);
    assign pre_tick = enable && (count == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte, sends it 8N1 LSB first, repeats.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         next_state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_next;
    logic              tick;
    logic              pre_tick;
    logic              bit_active;
    logic              cnt_clear;
    logic              tx_next;
    logic              rd_en_next;
    logic              busy_next;
    logic              done_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (bit_active),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        bit_active = 1'b0;
        case (state)
            START, DATA, STOP: bit_active = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:            bit_active = 1'b1;
`endif
            default:           bit_active = 1'b0;
        endcase
    end

    assign cnt_clear = (state == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!fifo_empty) next_state = POP;
            POP:   next_state = LOAD;
            LOAD:  next_state = START;
            START: if (tick) next_state = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:   if (tick && bit_idx == LAST_BIT) next_state = PARITY;
            PARITY: if (tick) next_state = STOP;
`else
            DATA:  if (tick && bit_idx == LAST_BIT) next_state = STOP;
`endif
            STOP:  if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shifter and bit index; fifo_data is only looked at in LOAD.
    always_comb begin
        shift_next   = shift;
        bit_idx_next = bit_idx;
        case (state)
            LOAD:  shift_next = fifo_data;
            START: bit_idx_next = '0;
            DATA: begin
                if (tick) begin
                    shift_next   = shift >> 1;
                    bit_idx_next = bit_idx + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == LOAD) begin
            parity_bit <= ^fifo_data;
        end
    end
`endif

    // Outputs are decoded from the next state so the registered line level
    // lines up exactly with the state it belongs to.
    always_comb begin
        rd_en_next = (next_state == POP);
        busy_next  = (next_state != IDLE);
        done_next  = (state == STOP) && pre_tick;
        case (next_state)
            START:   tx_next = UART_START_LEVEL;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx         <= UART_IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            tx         <= tx_next;
            fifo_rd_en <= rd_en_next;
            busy       <= busy_next;
            byte_done  <= done_next;
        end
    end

endmodule
